// File: rtl/wb_commit_arbiter.sv
// Multi-channel write-back commit: per-channel select + FIFO, round-robin drain to one RF write port.
// Define WB_COMMIT_FWD_EN to add the combinational forwarding lookup (fwd_addr/fwd_hit/fwd_data).

module wb_commit_fifo #(
   parameter int DEPTH = 2,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    push,
   input  logic [AW-1:0]           push_rw,
   input  logic [DW-1:0]           push_data,
   input  logic                    pop,
   output logic [AW-1:0]           head_rw,
   output logic [DW-1:0]           head_data,
   output logic [$clog2(DEPTH):0]  count
`ifdef WB_COMMIT_FWD_EN
   ,
   input  logic [AW-1:0]           fwd_addr,
   output logic                    fwd_hit,
   output logic [DW-1:0]           fwd_data
`endif
);
   localparam int PW   = $clog2(DEPTH);
   localparam int CNTW = PW + 1;

   typedef struct packed {
      logic [AW-1:0] rw;
      logic [DW-1:0] data;
   } ent_t;

   ent_t          mem [DEPTH];
   logic [PW-1:0] wp, rp;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) wp <= wp + PW'(1);
         if (pop)  rp <= rp + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CNTW'(1);
            2'b01:   count <= count - CNTW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (push) mem[wp] <= '{rw: push_rw, data: push_data};
   end

   assign head_rw   = mem[rp].rw;
   assign head_data = mem[rp].data;

`ifdef WB_COMMIT_FWD_EN
   logic [PW-1:0] slot;

   // Walk oldest to youngest so the youngest match overrides.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      slot     = '0;
      for (int k = 0; k < DEPTH; k++) begin
         slot = rp + PW'(k);
         if (CNTW'(k) < count && mem[slot].rw == fwd_addr) begin
            fwd_hit  = 1'b1;
            fwd_data = mem[slot].data;
         end
      end
   end
`endif
endmodule

module wb_commit_arbiter #(
   parameter int NCH   = 2,
   parameter int DEPTH = 2,
   parameter int DW    = 32,
   parameter int AW    = 5,
   localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [NCH-1:0]    in_valid,
   output logic [NCH-1:0]    in_ready,
   input  logic [NCH*AW-1:0] in_rw,
   input  logic [NCH*2-1:0]  in_sel,
   input  logic [NCH*DW-1:0] in_result,
   input  logic [NCH*DW-1:0] in_dmemload,
   input  logic [NCH*DW-1:0] in_pcinc,
   output logic              wen,
   output logic [AW-1:0]     wsel,
   output logic [DW-1:0]     wdat,
   output logic [CW-1:0]     wch,
   output logic              busy
`ifdef WB_COMMIT_FWD_EN
   ,
   input  logic [AW-1:0]     fwd_addr,
   output logic              fwd_hit,
   output logic [DW-1:0]     fwd_data
`endif
);
   localparam int PW = $clog2(DEPTH);

   logic [NCH-1:0]         push, pop, nempty;
   logic [NCH-1:0][AW-1:0] head_rw;
   logic [NCH-1:0][DW-1:0] head_data;
   logic [NCH-1:0][PW:0]   count;
`ifdef WB_COMMIT_FWD_EN
   logic [NCH-1:0]         ch_hit;
   logic [NCH-1:0][DW-1:0] ch_fwd;
`endif

   logic [CW-1:0] rr_ptr, gnt_idx;
   logic          gnt_vld;
   int            cand;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [AW-1:0] rw;
      logic [DW-1:0] dsel;

      assign rw = in_rw[i*AW +: AW];

      always_comb begin
         case (in_sel[i*2 +: 2])
            2'b01:   dsel = in_dmemload[i*DW +: DW];
            2'b10:   dsel = in_pcinc[i*DW +: DW];
            default: dsel = in_result[i*DW +: DW];
         endcase
      end

      // DEPTH is a power of two, so the count MSB is set only when full.
      assign in_ready[i] = ~count[i][PW];
      assign nempty[i]   = |count[i];
      assign push[i]     = in_valid[i] & in_ready[i] & (rw != '0);
      assign pop[i]      = gnt_vld && (gnt_idx == CW'(i));

      wb_commit_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
         .CLK       (CLK),
         .RST       (RST),
         .push      (push[i]),
         .push_rw   (rw),
         .push_data (dsel),
         .pop       (pop[i]),
         .head_rw   (head_rw[i]),
         .head_data (head_data[i]),
         .count     (count[i])
`ifdef WB_COMMIT_FWD_EN
         ,
         .fwd_addr  (fwd_addr),
         .fwd_hit   (ch_hit[i]),
         .fwd_data  (ch_fwd[i])
`endif
      );
   end

   // Scan downward from the farthest offset so the nearest candidate at/after rr_ptr wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = 0;
      for (int j = NCH - 1; j >= 0; j--) begin
         cand = (int'(rr_ptr) + j) % NCH;
         if (nempty[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = CW'(cand);
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wen    <= 1'b0;
         wsel   <= '0;
         wdat   <= '0;
         wch    <= '0;
         rr_ptr <= '0;
      end else begin
         wen <= gnt_vld;
         if (gnt_vld) begin
            wsel   <= head_rw[gnt_idx];
            wdat   <= head_data[gnt_idx];
            wch    <= gnt_idx;
            rr_ptr <= (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + CW'(1);
         end
      end
   end

   assign busy = (|nempty) | wen;

`ifdef WB_COMMIT_FWD_EN
   // Output register is lowest priority; lower channel index overrides higher.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      if (fwd_addr != '0) begin
         if (wen && wsel == fwd_addr) begin
            fwd_hit  = 1'b1;
            fwd_data = wdat;
         end
         for (int i = NCH - 1; i >= 0; i--) begin
            if (ch_hit[i]) begin
               fwd_hit  = 1'b1;
               fwd_data = ch_fwd[i];
            end
         end
      end
   end
`endif
endmodule

// File: doc/wb_commit_arbiter.md
Name: wb_commit_arbiter

Overview:
- Parametrised successor to the single-channel write-back stage.
- Accepts NCH independent write-back channels, for example the ALU pipe and the load pipe. Each channel has a valid/ready handshake.
- For each channel it selects the write data (ALU result, memory load or PC+4) and buffers it in a per-channel FIFO.
- A round-robin arbiter drains the FIFOs into the single register-file write port.
- Sits between the MEM/WB latches and the register file.

Parameters:
NCH, 2, number of write-back channels (>=2)
DEPTH, 2, entries per channel FIFO (power of 2, >=2)
DW, 32, data word width
AW, 5, register address width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
in_valid  in  NCH  channel i offers a write
in_ready  out  NCH  channel i can accept a write
in_rw  in  NCH*AW  destination register per channel, channel i at [i*AW +: AW]
in_sel  in  NCH*2  data select per channel: 00 result, 01 dmemload, 10 pcinc, 11 result
in_result  in  NCH*DW  ALU result per channel
in_dmemload  in  NCH*DW  load data per channel
in_pcinc  in  NCH*DW  PC+4 per channel
wen  out  1  register-file write enable
wsel  out  AW  register-file write address
wdat  out  DW  register-file write data
wch  out  max(1,$clog2(NCH))  channel that produced the current write
busy  out  1  any FIFO non-empty or wen high

Behaviour:
- Reset, asynchronous, active-high:
  - All FIFOs empty.
  - wen=0, wsel=0, wdat=0, wch=0.
  - Round-robin pointer set so channel 0 has first priority.
  - Entries pending when RST asserts are discarded; no partial write occurs.
- Handshake:
  - in_ready[i] = (count[i] < DEPTH). It depends only on registered state, never on in_valid or on a same-cycle pop.
  - A transfer occurs on a rising edge with in_valid[i] && in_ready[i].
- Full FIFO:
  - in_ready stays 0 even in a cycle where that FIFO is being popped.
  - Ready reasserts the cycle after the pop.
- Data select:
  - Performed at enqueue; the FIFO stores {rw, data}.
  - sel=11 is treated as 00.
- Register 0:
  - A transfer with in_rw==0 completes the handshake but is not enqueued.
  - It never produces wen.
- Arbitration, every cycle:
  - Candidates are the channels with a non-empty FIFO.
  - The grant goes to the first candidate at or after the pointer, searching upward modulo NCH.
  - The granted FIFO head is popped.
  - On the next edge: wen=1, wsel=head.rw, wdat=head.data, wch=granted index.
  - The pointer moves to (granted+1) mod NCH.
  - With no candidates: wen=0, wsel/wdat/wch hold their previous values, pointer unchanged.
- Latency:
  - An entry enqueued at edge k can be granted in cycle k.
  - Its write appears on wen/wsel/wdat after edge k+1.
  - Minimum two edges from handshake to register-file write.
- Throughput: one register-file write per cycle, sustained.
- Ordering:
  - FIFO order is preserved within a channel.
  - Across channels only the round-robin rule applies. Upstream hazard logic must not issue the same rw on two channels with both in flight.
- Simultaneous push and pop on one channel: count unchanged; both take effect.
- Pointer wrap: (NCH-1)+1 wraps to 0.
- Counters: per-channel count is $clog2(DEPTH)+1 bits. Read/write pointers are $clog2(DEPTH) bits and wrap naturally.

Optional Feature:
Macro: WB_COMMIT_FWD_EN
- When defined, adds three ports:
  - fwd_addr  in  AW
  - fwd_hit  out  1
  - fwd_data  out  DW
- fwd_hit=1 when fwd_addr!=0 and it matches any valid FIFO entry, or the output register while wen=1.
- fwd_data priority:
  - youngest matching entry within a channel;
  - among channels, lowest index wins;
  - output register lowest priority.
- Purely combinational lookup.
- fwd_hit=0 and fwd_data=0 in reset and when there is no match.
- When the macro is not defined, the ports and lookup logic are absent and the behaviour is otherwise identical.

Test Plan:
- Reset, then one channel-0 write (rw=5, sel=00, result=0xDEADBEEF) -> wen=1, wsel=5, wdat=0xDEADBEEF, wch=0 after the second edge from the handshake; wen=0 the next cycle.
- Both channels valid every cycle for 8 cycles (distinct rw 1..16, sel=01/10) -> wch alternates 0,1,0,1; wen high continuously from cycle 2; each data value selected by its sel; no loss.
- Stall: channel 1 pushes DEPTH+1 entries while channel 0 floods -> in_ready[1] drops after DEPTH accepted, reasserts one cycle after its first pop; all entries drain in FIFO order.
- rw=0 write with result=0x1234 -> in_ready honoured, no wen, busy stays 0.
- RST pulsed mid-burst with 3 entries pending -> outputs 0 immediately, in_ready all 1, no stale write after release; the first post-reset grant goes to channel 0.
- WB_COMMIT_FWD_EN: rw=7 queued on both channels (ch0 data 0xA, ch1 data 0xB), fwd_addr=7 -> fwd_hit=1, fwd_data=0xA; fwd_addr=0 -> fwd_hit=0.
